// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath result selector.
package alu_pkg;

  localparam int SEL_W = 4;
  localparam int N_IN  = 16;

endpackage : alu_pkg

// File: rtl/mux4to1.sv
// Combinational 4:1 word selector; building block of the 16:1 result mux.
module mux4to1 #(
  parameter int w = 8
) (
  input  logic [w-1:0] in_0,
  input  logic [w-1:0] in_1,
  input  logic [w-1:0] in_2,
  input  logic [w-1:0] in_3,
  input  logic [1:0]   sel,
  output logic [w-1:0] out
);

  always_comb begin
    out = in_0;
    case (sel)
      2'd0: out = in_0;
      2'd1: out = in_1;
      2'd2: out = in_2;
      2'd3: out = in_3;
      default: out = in_0;
    endcase
  end

endmodule : mux4to1

// File: rtl/mux_16to1.sv
// 16:1 word selector with one registered output stage and async active-low reset.
module mux_16to1
  import alu_pkg::*;
#(
  parameter int w = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [w-1:0]     in_0,
  input  logic [w-1:0]     in_1,
  input  logic [w-1:0]     in_2,
  input  logic [w-1:0]     in_3,
  input  logic [w-1:0]     in_4,
  input  logic [w-1:0]     in_5,
  input  logic [w-1:0]     in_6,
  input  logic [w-1:0]     in_7,
  input  logic [w-1:0]     in_8,
  input  logic [w-1:0]     in_9,
  input  logic [w-1:0]     in_10,
  input  logic [w-1:0]     in_11,
  input  logic [w-1:0]     in_12,
  input  logic [w-1:0]     in_13,
  input  logic [w-1:0]     in_14,
  input  logic [w-1:0]     in_15,
  input  logic [SEL_W-1:0] sel,
  output logic [w-1:0]     out
);

  logic [w-1:0] grp_out [4];
  logic [w-1:0] sel_out;
  logic [w-1:0] out_d;
  logic [w-1:0] out_q;

  // First level picks within each group of four using the low select bits.
  mux4to1 #(.w(w)) u_grp0 (
    .in_0(in_0),  .in_1(in_1),  .in_2(in_2),  .in_3(in_3),
    .sel(sel[1:0]), .out(grp_out[0])
  );

  mux4to1 #(.w(w)) u_grp1 (
    .in_0(in_4),  .in_1(in_5),  .in_2(in_6),  .in_3(in_7),
    .sel(sel[1:0]), .out(grp_out[1])
  );

  mux4to1 #(.w(w)) u_grp2 (
    .in_0(in_8),  .in_1(in_9),  .in_2(in_10), .in_3(in_11),
    .sel(sel[1:0]), .out(grp_out[2])
  );

  mux4to1 #(.w(w)) u_grp3 (
    .in_0(in_12), .in_1(in_13), .in_2(in_14), .in_3(in_15),
    .sel(sel[1:0]), .out(grp_out[3])
  );

  mux4to1 #(.w(w)) u_top (
    .in_0(grp_out[0]), .in_1(grp_out[1]), .in_2(grp_out[2]), .in_3(grp_out[3]),
    .sel(sel[SEL_W-1:2]), .out(sel_out)
  );

  always_comb begin
    out_d = sel_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : mux_16to1

// File: tb/tb_mux_16to1.sv
// Self-checking bench for mux_16to1 at widths 8, 16 and 64 using expected-value queues.
module tb_mux_16to1;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in8  [16];
  logic [15:0] in16 [16];
  logic [63:0] in64 [16];
  logic [3:0]  sel8, sel16, sel64;
  logic [7:0]  out8;
  logic [15:0] out16;
  logic [63:0] out64;

  logic [7:0]  q8  [$];
  logic [15:0] q16 [$];
  logic [63:0] q64 [$];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_16to1 #(.w(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_0(in8[0]),   .in_1(in8[1]),   .in_2(in8[2]),   .in_3(in8[3]),
    .in_4(in8[4]),   .in_5(in8[5]),   .in_6(in8[6]),   .in_7(in8[7]),
    .in_8(in8[8]),   .in_9(in8[9]),   .in_10(in8[10]), .in_11(in8[11]),
    .in_12(in8[12]), .in_13(in8[13]), .in_14(in8[14]), .in_15(in8[15]),
    .sel(sel8), .out(out8)
  );

  mux_16to1 #(.w(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_0(in16[0]),   .in_1(in16[1]),   .in_2(in16[2]),   .in_3(in16[3]),
    .in_4(in16[4]),   .in_5(in16[5]),   .in_6(in16[6]),   .in_7(in16[7]),
    .in_8(in16[8]),   .in_9(in16[9]),   .in_10(in16[10]), .in_11(in16[11]),
    .in_12(in16[12]), .in_13(in16[13]), .in_14(in16[14]), .in_15(in16[15]),
    .sel(sel16), .out(out16)
  );

  mux_16to1 #(.w(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_0(in64[0]),   .in_1(in64[1]),   .in_2(in64[2]),   .in_3(in64[3]),
    .in_4(in64[4]),   .in_5(in64[5]),   .in_6(in64[6]),   .in_7(in64[7]),
    .in_8(in64[8]),   .in_9(in64[9]),   .in_10(in64[10]), .in_11(in64[11]),
    .in_12(in64[12]), .in_13(in64[13]), .in_14(in64[14]), .in_15(in64[15]),
    .sel(sel64), .out(out64)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic missing_entry(input string tag);
    checks++;
    failures++;
    $error("[TB] FAIL %s observed=no-entry expected=queued-value", tag);
  endtask

  task automatic check_q8(input string tag);
    logic [7:0] e;
    if (q8.size() == 0) missing_entry(tag);
    else begin
      e = q8.pop_front();
      check_output(tag, 64'(out8), 64'(e));
    end
  endtask

  task automatic check_q16(input string tag);
    logic [15:0] e;
    if (q16.size() == 0) missing_entry(tag);
    else begin
      e = q16.pop_front();
      check_output(tag, 64'(out16), 64'(e));
    end
  endtask

  task automatic check_q64(input string tag);
    logic [63:0] e;
    if (q64.size() == 0) missing_entry(tag);
    else begin
      e = q64.pop_front();
      check_output(tag, out64, e);
    end
  endtask

  // Advance to just after the next rising edge, where registered outputs are stable.
  task automatic apply_stimulus;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    sel8     = 4'd5;
    sel16    = 4'd0;
    sel64    = 4'd0;
    for (int k = 0; k < 16; k++) begin
      in8[k]  = 8'h00;
      in16[k] = 16'h0000;
      in64[k] = 64'h0;
    end
    in8[5] = 8'h7F;

    // Reset held: output must stay zero across edges.
    for (int i = 0; i < 3; i++) begin
      q8.push_back(8'h00);
      apply_stimulus();
      check_q8("reset_hold");
    end

    @(negedge clk);
    rst_n = 1'b1;
    q8.push_back(8'h7F);
    apply_stimulus();
    check_q8("reset_release");

    // Full select sweep at w=8.
    @(negedge clk);
    for (int k = 0; k < 16; k++) in8[k] = 8'(k * 16 + 3);
    for (int s = 0; s < 16; s++) begin
      if (s != 0) @(negedge clk);
      sel8 = 4'(s);
      q8.push_back(8'(s * 16 + 3));
      apply_stimulus();
      check_q8($sformatf("sweep_sel%0d", s));
    end

    // Signed values pass through untouched at w=16.
    @(negedge clk);
    in16[0]  = 16'h8000;
    in16[15] = 16'h7FFF;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      sel16 = (i % 2 == 0) ? 4'd0 : 4'd15;
      q16.push_back((i % 2 == 0) ? 16'h8000 : 16'h7FFF);
      apply_stimulus();
      check_q16("signed_pass");
    end

    // Select glitch between edges must not reach the output.
    @(negedge clk);
    in8[3] = 8'hA5;
    in8[9] = 8'h5A;
    sel8   = 4'd3;
    q8.push_back(8'hA5);
    apply_stimulus();
    check_q8("glitch_setup");
    @(negedge clk);
    sel8 = 4'd9;
    #2;
    check_output("glitch_mid", 64'(out8), 64'hA5);
    sel8 = 4'd3;
    q8.push_back(8'hA5);
    apply_stimulus();
    check_q8("glitch_after");

    // Async reset pulse between edges at w=64.
    @(negedge clk);
    in64[7] = 64'hDEAD_BEEF_0123_4567;
    sel64   = 4'd7;
    q64.push_back(64'hDEAD_BEEF_0123_4567);
    q64.push_back(64'hDEAD_BEEF_0123_4567);
    apply_stimulus();
    check_q64("w64_load");
    apply_stimulus();
    check_q64("w64_steady");
    #2;
    rst_n = 1'b0;
    #1;
    check_output("w64_async_clear", out64, 64'h0);
    #1;
    rst_n = 1'b1;
    #1;
    check_output("w64_held_until_edge", out64, 64'h0);
    q64.push_back(64'hDEAD_BEEF_0123_4567);
    apply_stimulus();
    check_q64("w64_reload");

    // Random inputs and selects at w=8 and w=16, compared against in_[sel].
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
        in8[k]  = 8'($urandom);
        in16[k] = 16'($urandom);
      end
      sel8  = 4'($urandom_range(15, 0));
      sel16 = 4'($urandom_range(15, 0));
      q8.push_back(in8[sel8]);
      q16.push_back(in16[sel16]);
      apply_stimulus();
      check_q8("rand_w8");
      check_q16("rand_w16");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_16to1
